countdown_timer_n: RTL and testbench

//  Parametrised countdown timer with N-digit BCD value, multiplexed 7-seg display,

---
 rtl/countdown_pkg.sv | 46 ++++
 rtl/key_debounce.sv | 46 ++++
 rtl/countdown_timer_n.sv | 183 ++++++++++++++++++
 tb/tb_countdown_timer_n.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: FSM states, display glyph codes and the
// 7-segment decoder. Pure combinational helpers, no latency, no backpressure.
package countdown_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  localparam logic [3:0] GL_BLANK = 4'hA;
  localparam logic [3:0] GL_E     = 4'hB;
  localparam logic [3:0] GL_N     = 4'hC;
  localparam logic [3:0] GL_D     = 4'hD;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is never lit.
  function automatic logic [7:0] seg7(input logic [3:0] glyph);
    case (glyph)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      GL_E:    seg7 = 8'h86;
      GL_N:    seg7 = 8'hAB;
      GL_D:    seg7 = 8'hA1;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser + debouncer: one-cycle rel_pulse after DEBOUNCE_CYC stable low then
// DEBOUNCE_CYC stable high; latency 2 sync flops + DEBOUNCE_CYC + 1; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clkin,
  input  logic rst,
  input  logic key,
  output logic rel_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync;
  logic          pressed;
  logic [CW-1:0] cnt;
  logic          level;

  assign level = sync[1];

  always_ff @(posedge clkin) begin
    if (rst) begin
      sync      <= 2'b11;
      pressed   <= 1'b0;
      cnt       <= '0;
      rel_pulse <= 1'b0;
    end else begin
      sync      <= {sync[0], key};
      rel_pulse <= 1'b0;
      // While released we wait for a stable low, while pressed for a stable high.
      if (level == pressed) begin
        if (cnt == CNT_LAST) begin
          cnt       <= '0;
          pressed   <= ~pressed;
          rel_pulse <= pressed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_n.sv
// BCD countdown timer with key UI, scanned 7-seg display and alarm; outputs registered,
// keys act one cycle after their debounced release, no backpressure. Option: BLINK_EN.
module countdown_timer_n
  import countdown_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int TICK_CYC     = 50_000_000,
  parameter int SCAN_CYC     = 100_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int ALARM_CYC    = 0
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              ke,
  input  logic              ku,
  input  logic              kd,
  input  logic              kl,
  input  logic              kr,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        led,
  output logic              alarm,
  output logic [2:0]        state_o
);

  localparam int LAST = DIGITS - 1;
  localparam int IW   = $clog2(DIGITS);
  localparam int TW   = $clog2(TICK_CYC + 1);
  localparam int SW   = $clog2(SCAN_CYC + 1);
  localparam int AW   = (ALARM_CYC > 0) ? $clog2(ALARM_CYC + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYC - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYC - 1);
  localparam logic [AW-1:0] ALARM_LAST = (ALARM_CYC > 0) ? AW'(ALARM_CYC - 1) : '0;
  localparam logic [DIGITS-1:0] POS0   = 1;
`ifdef BLINK_EN
  localparam logic [TW-1:0] TICK_HALF  = TW'(TICK_CYC / 2);
`endif

  state_t              state;
  logic [DIGITS*4-1:0] value;
  logic [IW-1:0]       cursor, scan_idx;
  logic [TW-1:0]       tick_cnt;
  logic [SW-1:0]       scan_cnt;
  logic [AW-1:0]       alarm_cnt;
  logic [4:0]          keys, rel;
  logic                ev_e, ev_u, ev_d, ev_l, ev_r;
  logic [3:0]          cur_digit, glyph;
  logic                alarm_timeout;

  assign keys = {ke, ku, kd, kl, kr};

  for (genvar g = 0; g < 5; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clkin    (clkin),
      .rst      (rst),
      .key      (keys[g]),
      .rel_pulse(rel[g])
    );
  end

  assign ev_e = rel[4];
  assign ev_u = rel[3] & ~rel[4];
  assign ev_d = rel[2] & ~|rel[4:3];
  assign ev_l = rel[1] & ~|rel[4:2];
  assign ev_r = rel[0] & ~|rel[4:1];

  // Position 0 is the leftmost digit, i.e. the most significant nibble.
  assign cur_digit     = value[(LAST - int'(cursor))*4 +: 4];
  assign alarm_timeout = (ALARM_CYC > 0) && (alarm_cnt == ALARM_LAST);
  assign state_o       = state;

  function automatic logic [DIGITS*4-1:0] dec_value(input logic [DIGITS*4-1:0] v);
    logic borrow;
    dec_value = v;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        dec_value[i*4 +: 4] = bcd_dec(v[i*4 +: 4]);
        borrow = (v[i*4 +: 4] == 4'd0);
      end
    end
  endfunction

  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= ST_IDLE;
      value     <= '0;
      cursor    <= IW'(LAST);
      tick_cnt  <= '0;
      alarm_cnt <= '0;
      alarm     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (ev_e) begin
          state    <= ST_SET;
          value    <= '0;
          cursor   <= IW'(LAST);
          tick_cnt <= '0;
        end
        ST_SET: begin
`ifdef BLINK_EN
          tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
`endif
          if (ev_e) begin
            state    <= ST_RUN;
            tick_cnt <= '0;
          end else if (ev_u) value[(LAST - int'(cursor))*4 +: 4] <= bcd_inc(cur_digit);
          else if (ev_d) value[(LAST - int'(cursor))*4 +: 4] <= bcd_dec(cur_digit);
          else if (ev_l) cursor <= (cursor == '0) ? IW'(LAST) : cursor - 1'b1;
          else if (ev_r) cursor <= (cursor == IW'(LAST)) ? '0 : cursor + 1'b1;
        end
        ST_RUN: begin
          if (value == '0) begin
            state     <= ST_ALARM;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
          end else if (ev_e) begin
            state <= ST_PAUSE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            value    <= dec_value(value);
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (ev_e) state <= ST_RUN;
          else if (ev_u) state <= ST_SET;
        end
        ST_ALARM: begin
          if (ev_e || alarm_timeout) begin
            state <= ST_IDLE;
            alarm <= 1'b1;
            value <= '0;
          end else begin
            alarm_cnt <= alarm_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    glyph = GL_BLANK;
    case (state)
      ST_IDLE:                  glyph = 4'd0;
      ST_SET, ST_RUN, ST_PAUSE: glyph = value[(LAST - int'(scan_idx))*4 +: 4];
      ST_ALARM: begin
        if (DIGITS >= 3 && int'(scan_idx) >= DIGITS - 3) begin
          case (int'(scan_idx) - (DIGITS - 3))
            0:       glyph = GL_E;
            1:       glyph = GL_N;
            default: glyph = GL_D;
          endcase
        end
      end
      default: glyph = GL_BLANK;
    endcase
`ifdef BLINK_EN
    if (state == ST_SET && scan_idx == cursor && tick_cnt >= TICK_HALF) glyph = GL_BLANK;
`endif
  end

  // sel and led come from the same scan_idx so they always change together.
  always_ff @(posedge clkin) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      sel      <= '1;
      led      <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(LAST)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      sel <= ~(POS0 << scan_idx);
      led <= seg7(glyph);
    end
  end

endmodule

// File: tb/tb_countdown_timer_n.sv
// Bench for countdown_timer_n: directed key sequences with random timing/values,
// checked against an elapsed-run-time decimal model of the countdown.
module tb_countdown_timer_n;

  localparam int TICK = 20;
  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_RUN = 3'd2, S_PAUSE = 3'd3, S_ALARM = 3'd4;
  localparam logic [4:0] K_E = 5'b10000, K_U = 5'b01000, K_D = 5'b00100, K_L = 5'b00010, K_R = 5'b00001;
  localparam int G_BLANK = 10, G_E = 11, G_N = 12, G_D = 13;

  logic clk = 1'b0, rst = 1'b1;
  logic ke = 1'b1, ku = 1'b1, kd = 1'b1, kl = 1'b1, kr = 1'b1;
  logic [3:0] sel;
  logic [7:0] led;
  logic       alarm;
  logic [2:0] state_o;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int run_adv = 0, m_val = 0, set_val = 0, prev_val = 0;
  logic [2:0] prev_st = S_IDLE;
  logic [7:0] disp [4];

  countdown_timer_n #(
    .DIGITS(4), .TICK_CYC(TICK), .SCAN_CYC(4), .DEBOUNCE_CYC(3), .ALARM_CYC(50)
  ) dut (
    .clkin(clk), .rst(rst), .ke(ke), .ku(ku), .kd(kd), .kl(kl), .kr(kr),
    .sel(sel), .led(led), .alarm(alarm), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input int g);
    logic [6:0] on;  // gfedcba, 1 = lit
    case (g)
      0: on = 7'h3F; 1: on = 7'h06; 2: on = 7'h5B; 3: on = 7'h4F; 4: on = 7'h66;
      5: on = 7'h6D; 6: on = 7'h7D; 7: on = 7'h07; 8: on = 7'h7F; 9: on = 7'h6F;
      G_E: on = 7'h79; G_N: on = 7'h54; G_D: on = 7'h5E;
      default: on = 7'h00;
    endcase
    return ~{1'b0, on};
  endfunction

  function automatic int digit_of(input int v, input int pos);
    int p = 1;
    for (int i = 0; i < 3 - pos; i++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int j = 0; j < 4; j++) r[j*4 +: 4] = 4'(digit_of(v, 3 - j));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock; the countdown model advances only on cycles that stay in RUN.
  task automatic step();
    logic [2:0] cur;
    @(negedge clk);
    cyc++;
    cur = state_o;
    if (!rst) begin
      if (prev_st == S_RUN && prev_val == 0) check("alarm_entry", 32'(cur), 32'(S_ALARM));
      if (prev_st == S_SET && cur == S_RUN) begin
        run_adv = 0;
        m_val   = set_val;
      end else if (prev_st == S_RUN && cur == S_RUN) begin
        run_adv++;
        if (run_adv % TICK == 0 && m_val > 0) m_val--;
      end
      if (cur == S_RUN || cur == S_PAUSE) check("run_value", 32'(dut.value), 32'(to_bcd(m_val)));
    end
    prev_st  = cur;
    prev_val = m_val;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int i = 0;
    while (state_o !== st && i < budget) begin
      step();
      i++;
    end
    check(tag, 32'(state_o), 32'(st));
  endtask

  task automatic key_down(input logic [4:0] mask);
    {ke, ku, kd, kl, kr} = ~mask;
  endtask

  task automatic key_up();
    {ke, ku, kd, kl, kr} = 5'h1F;
  endtask

  task automatic press(input logic [4:0] mask);
    key_down(mask);
    repeat ($urandom_range(4, 7)) step();
    key_up();
    repeat (12) step();
  endtask

  task automatic expect_disp(input string tag, input int g0, input int g1, input int g2, input int g3);
    logic [3:0] seen = '0;
    int want [4];
    want = '{g0, g1, g2, g3};
    for (int i = 0; i < 48 && seen != 4'hF; i++) begin
      step();
      for (int j = 0; j < 4; j++)
        if (sel == ~(4'b0001 << j)) begin
          disp[j] = led;
          seen[j] = 1'b1;
        end
    end
    check({tag, "_scan"}, 32'(seen), 32'hF);
    for (int j = 0; j < 4; j++) check($sformatf("%s_d%0d", tag, j), 32'(disp[j]), 32'(seg_of(want[j])));
  endtask

  task automatic expect_val_disp(input string tag, input int v);
    expect_disp(tag, digit_of(v, 0), digit_of(v, 1), digit_of(v, 2), digit_of(v, 3));
  endtask

  task automatic set_digit(input int dv);
    if (dv <= 5) repeat (dv) press(K_U);
    else repeat (10 - dv) press(K_D);
  endtask

  initial begin
    int ph, k, r, t0, val;
    int d [4];
    logic [15:0] v0;

    repeat (3) step();
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    check("rst_alarm", 32'(alarm), 32'd1);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_led", 32'(led), 32'hFF);
    rst = 1'b0;
    expect_val_disp("idle_disp", 0);

    // Short bounces must not register as a key action.
    for (int i = 0; i < 3; i++) begin
      key_down(K_E);
      repeat ($urandom_range(1, 2)) step();
      key_up();
      repeat ($urandom_range(12, 20)) step();
      check("bounce_idle", 32'(state_o), 32'(S_IDLE));
    end

    press(K_E);
    wait_state("idle_to_set", S_SET, 20);
    expect_val_disp("set_zero", 0);
    press(K_D);
    press(K_R);
    repeat (3) press(K_U);
    expect_val_disp("set_3009", 3009);

    // Run, pause, resume: next decrement comes when the remaining tick elapses.
    set_val = 3009;
    press(K_E);
    wait_state("set_to_run", S_RUN, 20);
    repeat ($urandom_range(25, 70)) step();
    press(K_E);
    wait_state("run_to_pause", S_PAUSE, 20);
    ph = run_adv % TICK;
    repeat (40) step();
    expect_val_disp("pause_disp", m_val);
    press(K_L);
    press(K_R);
    check("pause_ignores_lr", 32'(state_o), 32'(S_PAUSE));
    key_down(K_E);
    repeat ($urandom_range(4, 7)) step();
    key_up();
    wait_state("pause_to_run", S_RUN, 20);
    v0 = dut.value;
    k = 0;
    while (dut.value === v0 && k < 40) begin
      step();
      k++;
    end
    check("resume_dec_cycles", 32'(k), 32'(TICK - ph));
    press(K_E);
    wait_state("run_to_pause2", S_PAUSE, 20);
    press(K_U);
    wait_state("pause_to_set", S_SET, 20);
    check("pause_set_value", 32'(dut.value), 32'(to_bcd(m_val)));
    set_val = m_val;
    press(K_E);
    wait_state("set_to_run2", S_RUN, 20);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("mid_rst_state", 32'(state_o), 32'(S_IDLE));
    check("mid_rst_alarm", 32'(alarm), 32'd1);
    check("mid_rst_sel", 32'(sel), 32'hF);
    check("mid_rst_led", 32'(led), 32'hFF);
    rst = 1'b0;
    step();

    // 0100 counts down to ALARM, then auto-returns to IDLE.
    press(K_E);
    wait_state("idle_to_set2", S_SET, 20);
    press(K_L);
    press(K_L);
    press(K_U);
    set_val = 100;
    press(K_E);
    wait_state("set_to_run3", S_RUN, 20);
    k = 0;
    while (run_adv < TICK && k < 40) begin
      step();
      k++;
    end
    check("first_tick_0099", 32'(dut.value), 32'h0099);
    wait_state("run_to_alarm", S_ALARM, 2200);
    t0 = cyc;
    check("alarm_run_cycles", 32'(run_adv), 32'(100 * TICK));
    check("alarm_low", 32'(alarm), 32'd0);
    expect_disp("end_disp", G_BLANK, G_E, G_N, G_D);
    wait_state("alarm_timeout", S_IDLE, 100);
    check("alarm_timeout_cycles", 32'(cyc - t0), 32'd50);
    check("alarm_high", 32'(alarm), 32'd1);

    // ke and ku released together in SET: ke wins, digit untouched.
    r = $urandom_range(1, 5);
    press(K_E);
    wait_state("idle_to_set3", S_SET, 20);
    repeat (r) press(K_U);
    set_val = r;
    press(K_E | K_U);
    check("ke_ku_state", 32'(state_o), 32'(S_RUN));
    check("ke_ku_value", 32'(dut.value), 32'(to_bcd(r)));
    wait_state("small_alarm", S_ALARM, 150);
    t0 = cyc;
    press(K_E);
    wait_state("ke_exit_alarm", S_IDLE, 30);
    check("ke_exit_early", 32'((cyc - t0) < 50), 32'd1);
    check("ke_exit_alarm_high", 32'(alarm), 32'd1);

    // RUN entered with zero goes straight to ALARM.
    press(K_E);
    wait_state("idle_to_set4", S_SET, 20);
    set_val = 0;
    press(K_E);
    wait_state("zero_alarm", S_ALARM, 30);
    wait_state("zero_alarm_timeout", S_IDLE, 60);

    // Random value dialled with ku/kd and cursor moves, run, pause, read back.
    d[0] = $urandom_range(1, 9);
    for (int j = 1; j < 4; j++) d[j] = $urandom_range(0, 9);
    val = d[0] * 1000 + d[1] * 100 + d[2] * 10 + d[3];
    press(K_E);
    wait_state("idle_to_set5", S_SET, 20);
    set_digit(d[3]);
    press(K_R);
    set_digit(d[0]);
    press(K_R);
    set_digit(d[1]);
    press(K_R);
    set_digit(d[2]);
    expect_val_disp("rand_set", val);
    set_val = val;
    press(K_E);
    wait_state("rand_run", S_RUN, 20);
    repeat ($urandom_range(60, 200)) step();
    press(K_E);
    wait_state("rand_pause", S_PAUSE, 20);
    expect_val_disp("rand_pause_disp", m_val);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
